// File: rtl/alu_unit_20_pkg.sv
// Shared definitions for the 20-series ALU: operation codes, FSM states and
// the bit positions of the {Z, N, C, V} flag vector.
package alu_pkg_20;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [3:0] make_flags(input logic z, input logic n,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_unit_20_seq_muldiv.sv
// Iterative unsigned multiplier / restoring divider, one bit per step.
// Outputs show the value after the step being taken this cycle.
module seq_muldiv_20
  import alu_pkg_20::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  // hi holds the upper product half or the partial remainder; lo holds the
  // multiplier bits still to consume or the dividend bits turning into quotient.
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_sh  = {hi_q, lo_q[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, opnd_q};

  always_comb begin
    step_hi = '0;
    step_lo = '0;
    if (div_q) begin
      step_hi = div_ge ? (div_sh[WIDTH-1:0] - opnd_q) : div_sh[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    if (load) begin
      hi_d   = '0;
      lo_d   = a;
      opnd_d = b;
      div_d  = is_div;
      cnt_d  = '0;
    end else if (step) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
    end
  end

  assign last      = step && (cnt_q == CW'(WIDTH - 1));
  assign prod_lo   = step_lo;
  assign prod_hi   = step_hi;
  assign quotient  = step_lo;
  assign remainder = step_hi;

endmodule

// File: rtl/alu_unit_20.sv
// Multi-cycle ALU: add/sub finish in one cycle, mul/div run WIDTH cycles.
// Handshake: start is taken only while busy=0; done pulses once with results.
module alu_unit_20
  import alu_pkg_20::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic [3:0]       flags,
  output logic             err,
  output logic [1:0]       dbg_state
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;

  logic             accept;
  logic             iterative;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic             md_last;
  logic [WIDTH-1:0] md_prod_lo, md_prod_hi, md_quot, md_rem;

  assign accept    = (state_q == ST_IDLE) && start;
  assign iterative = (ALUControl == OP_MUL) || ((ALUControl == OP_DIV) && (b != '0));
  assign add_full  = {1'b0, a} + {1'b0, b};
  assign add_sum   = add_full[WIDTH-1:0];
  assign sub_diff  = a - b;

  seq_muldiv_20 #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .load      (accept && iterative),
    .step      (state_q == ST_CALC),
    .is_div    (ALUControl == OP_DIV),
    .a         (a),
    .b         (b),
    .last      (md_last),
    .prod_lo   (md_prod_lo),
    .prod_hi   (md_prod_hi),
    .quotient  (md_quot),
    .remainder (md_rem)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    rem_d    = rem_q;
    flags_d  = flags_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = ALUControl;
          if (iterative) begin
            state_d = ST_CALC;
          end else begin
            // Single-cycle ops resolve here so results are visible in DONE.
            state_d = ST_DONE;
            rem_d   = '0;
            err_d   = 1'b0;
            case (ALUControl)
              OP_ADD: begin
                result_d = add_sum;
                flags_d  = make_flags(add_sum == '0, add_sum[WIDTH-1], add_full[WIDTH],
                                      (a[WIDTH-1] == b[WIDTH-1]) &&
                                      (add_sum[WIDTH-1] != a[WIDTH-1]));
              end
              OP_SUB: begin
                result_d = sub_diff;
                flags_d  = make_flags(sub_diff == '0, sub_diff[WIDTH-1], a < b,
                                      (a[WIDTH-1] != b[WIDTH-1]) &&
                                      (sub_diff[WIDTH-1] != a[WIDTH-1]));
              end
              OP_DIV: begin
                result_d = '1;
                rem_d    = a;
                err_d    = 1'b1;
                flags_d  = make_flags(1'b0, 1'b1, 1'b0, 1'b0);
              end
              default: begin
                result_d = '0;
                err_d    = 1'b1;
                flags_d  = make_flags(1'b1, 1'b0, 1'b0, 1'b0);
              end
            endcase
          end
        end
      end
      ST_CALC: begin
        if (md_last) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          if (op_q == OP_MUL) begin
            result_d = md_prod_lo;
            rem_d    = '0;
            flags_d  = make_flags(md_prod_lo == '0, md_prod_lo[WIDTH-1], 1'b0,
                                  md_prod_hi != '0);
          end else begin
            result_d = md_quot;
            rem_d    = md_rem;
            flags_d  = make_flags(md_quot == '0, md_quot[WIDTH-1], 1'b0, 1'b0);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      result_q <= '0;
      rem_q    <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign remainder = rem_q;
  assign flags     = flags_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
